// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcode constants and the immediate-format
// select codes consumed by fetch_stage and imm_gen.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_e;

  function automatic imm_sel_e imm_sel_decode(input logic [6:0] opcode);
    imm_sel_e sel;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: sel = IMM_I;
      OPC_STORE:                                  sel = IMM_S;
      OPC_BRANCH:                                 sel = IMM_B;
      OPC_LUI, OPC_AUIPC:                         sel = IMM_U;
      OPC_JAL:                                    sel = IMM_J;
      default:                                    sel = IMM_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for fetch_stage: DEPTH-entry FIFO of {pc, instruction}
// pairs with synchronous flush; push and pop may coincide when full.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic [31:0]                  push_pc,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  head_data,
  output logic [31:0]                  head_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// buffering, redirect flush/discard. Optional FETCH_STAGE_MISALIGN_CHK_EN.
import rv32i_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [2:0]  o_imm_sel
`ifdef FETCH_STAGE_MISALIGN_CHK_EN
  ,
  output logic        o_fetch_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic             ignore_stale;
  logic             fetch_err;
  logic             misaligned;
  logic [31:0]      redirect_target;
  logic [SUM_W-1:0] credit_used;
  logic             accept;
  logic             resp_live;
  logic             resp_keep;
  logic             pop;
  logic             has_head;
  logic [31:0]      head_data;
  logic [31:0]      head_pc;

  assign redirect_target = {i_redirect_pc[31:2], 2'b00};

`ifdef FETCH_STAGE_MISALIGN_CHK_EN
  assign misaligned  = |i_redirect_pc[1:0];
  assign o_fetch_err = fetch_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)        fetch_err <= 1'b0;
    else if (i_redirect) fetch_err <= misaligned;
  end
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign misaligned           = 1'b0;
  assign fetch_err            = 1'b0;
`endif

  assign credit_used = SUM_W'(in_flight) + SUM_W'(fifo_count);
  assign o_imem_req  = i_rst_n && !i_redirect && !fetch_err && (credit_used < CREDITS);
  assign o_imem_addr = fetch_pc;
  assign accept      = o_imem_req && i_imem_ready;

  // Responses to requests abandoned by reset are not counted in in_flight.
  assign resp_live = i_imem_rvalid && !ignore_stale;
  assign resp_keep = resp_live && (discard == '0) && !i_redirect;

  assign has_head = (fifo_count != '0);
  assign o_valid  = has_head && !i_redirect;
  assign pop      = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      in_flight    <= '0;
      discard      <= '0;
      ignore_stale <= 1'b1;
    end else begin
      in_flight <= in_flight + CNT_W'(accept) - CNT_W'(resp_live);
      if (accept) begin
        fetch_pc     <= fetch_pc + 32'd4;
        ignore_stale <= 1'b0;
      end
      // resp_pc tracks the PC of the next response that will be kept,
      // so no per-request PC queue is needed.
      if (i_redirect) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= in_flight - CNT_W'(resp_live);
      end else begin
        if (resp_keep) resp_pc <= resp_pc + 32'd4;
        if (resp_live && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_redirect),
    .push      (resp_keep),
    .push_data (i_imem_rdata),
    .push_pc   (resp_pc),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (head_data),
    .head_pc   (head_pc)
  );

  assign o_instruction = has_head ? head_data : '0;
  assign o_pc          = has_head ? head_pc   : '0;
  assign o_imm_sel     = imm_sel_decode(o_instruction[6:0]);

endmodule
